home_inventory_evt_detect: RTL and testbench

//  Per-channel weight-event detector, directly downstream of the home_inventory_wb register block.
//  - Inputs: raw ADC samples, time-multiplexed across channels.
//  - Uses the TARE/SCALE values held in the register block to compute a calibrated net value.
//  - Debounces changes in that value against a per-channel baseline.
//  - Feeds EVT_COUNT_CHn and the event IRQ source back to the register block.

---
 rtl/home_inventory_pkg.sv | 23 ++
 rtl/home_inventory_calib_mul.sv | 40 ++++
 rtl/home_inventory_evt_detect.sv | 197 +++++++++++++++++++
 tb/tb_home_inventory_evt_detect.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/home_inventory_pkg.sv
// Shared constants, FSM encoding and helpers for the home_inventory
// weight-event detector (channel width, Q16 shift, saturation limits).
package home_inventory_pkg;

  localparam int CH_W      = 3;
  localparam int Q16_SHIFT = 16;

  localparam logic signed [31:0] NET_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] NET_MIN = 32'sh8000_0000;
  localparam logic        [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MUL  = 2'd2,
    ST_CMP  = 2'd3
  } evt_state_t;

  function automatic logic signed [32:0] sext33(input logic [31:0] v);
    return $signed({v[31], v});
  endfunction

endpackage

// File: rtl/home_inventory_calib_mul.sv
// Registered signed 33x33 multiply, arithmetic >>>16, saturate to signed 32.
// Ports: clk, rst (sync, active-high), en (load), a/b (signed 33), q (signed 32).
module home_inventory_calib_mul
  import home_inventory_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [32:0] a,
  input  logic signed [32:0] b,
  output logic signed [31:0] q
);

  logic signed [65:0] w_a;
  logic signed [65:0] w_b;
  logic signed [65:0] w_prod;
  logic signed [65:0] w_sh;
  logic               w_ovp;
  logic               w_ovn;

  assign w_a    = $signed({{33{a[32]}}, a});
  assign w_b    = $signed({{33{b[32]}}, b});
  assign w_prod = w_a * w_b;
  assign w_sh   = w_prod >>> Q16_SHIFT;

  // Fits in signed 32 only when bits 65..31 are all equal.
  assign w_ovp = !w_sh[65] && (|w_sh[64:31]);
  assign w_ovn =  w_sh[65] && !(&w_sh[64:31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (w_ovp)      q <= NET_MAX;
      else if (w_ovn) q <= NET_MIN;
      else            q <= $signed(w_sh[31:0]);
    end
  end

endmodule

// File: rtl/home_inventory_evt_detect.sv
// Per-channel weight-event detector: calibrates raw ADC samples with
// TARE/SCALE, debounces deltas against a per-channel baseline, counts events.
// Ports: wb_clk_i/wb_rst_i (sync active-high), enable, in_* sample handshake,
// tare_flat/scale_flat/thresh/cnt_clr config, net_* calibrated output,
// evt_pulse/evt_ch/evt_count_flat event outputs.
// Option HOME_INV_EVT_TIMESTAMP_EN adds evt_ts (free-running cycle stamp).
module home_inventory_evt_detect
  import home_inventory_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_ch,
  input  logic [23:0]           in_raw,
  input  logic [NUM_CH*32-1:0]  tare_flat,
  input  logic [NUM_CH*32-1:0]  scale_flat,
  input  logic [31:0]           thresh,
  input  logic [NUM_CH-1:0]     cnt_clr,
  output logic                  net_valid,
  output logic [2:0]            net_ch,
  output logic [31:0]           net_data,
  output logic                  evt_pulse,
  output logic [2:0]            evt_ch,
`ifdef HOME_INV_EVT_TIMESTAMP_EN
  output logic [31:0]           evt_ts,
`endif
  output logic [NUM_CH*32-1:0]  evt_count_flat
);

  localparam int              NSLOT = 1 << CH_W;
  localparam logic [CH_W:0]   NCH   = (CH_W+1)'(NUM_CH);
  localparam logic [3:0]      DEB_N = 4'(DEBOUNCE);

  evt_state_t         r_state;
  logic [CH_W-1:0]    r_ch;
  logic [23:0]        r_raw;
  logic signed [32:0] r_diff;
  logic [31:0]        r_scale;

  logic signed [31:0] r_base [NSLOT];
  logic [NSLOT-1:0]   r_bv;
  logic [3:0]         r_deb  [NSLOT];
  logic [31:0]        r_cnt  [NUM_CH];

  logic [31:0]        w_tare  [NSLOT];
  logic [31:0]        w_scale [NSLOT];
  logic signed [31:0] w_net;
  logic signed [32:0] w_d;
  logic [32:0]        w_abs;
  logic               w_over;
  logic [3:0]         w_deb_n;
  logic               w_evt;
  logic               w_mul_en;

  for (genvar g = 0; g < NSLOT; g++) begin : g_cfg
    if (g < NUM_CH) begin : g_on
      assign w_tare[g]  = tare_flat[32*g +: 32];
      assign w_scale[g] = scale_flat[32*g +: 32];
    end else begin : g_off
      assign w_tare[g]  = '0;
      assign w_scale[g] = '0;
    end
  end

  assign in_ready = (r_state == ST_IDLE) && enable;
  assign w_mul_en = (r_state == ST_MUL) && enable;

  home_inventory_calib_mul u_mul (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .en  (w_mul_en),
    .a   (r_diff),
    .b   ($signed({1'b0, r_scale})),
    .q   (w_net)
  );

  assign net_data = w_net;

  always_comb begin
    w_d     = sext33(w_net) - sext33(r_base[r_ch]);
    w_abs   = w_d[32] ? -w_d : w_d;
    w_over  = w_abs > {1'b0, thresh};
    w_deb_n = r_deb[r_ch] + 4'd1;
    w_evt   = enable && (r_state == ST_CMP) && r_bv[r_ch]
              && w_over && (w_deb_n == DEB_N);
  end

  always_comb begin
    evt_count_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      evt_count_flat[32*i +: 32] = r_cnt[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_raw     <= '0;
      r_diff    <= '0;
      r_scale   <= '0;
      r_bv      <= '0;
      net_valid <= 1'b0;
      net_ch    <= '0;
      evt_pulse <= 1'b0;
      evt_ch    <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_base[i] <= '0;
        r_deb[i]  <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      net_valid <= 1'b0;
      evt_pulse <= 1'b0;
      if (!enable) begin
        // Drop the in-flight sample and forget all baselines.
        r_state <= ST_IDLE;
        r_bv    <= '0;
        for (int i = 0; i < NSLOT; i++) begin
          r_deb[i] <= '0;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            // Out-of-range channels are accepted and discarded.
            if (in_valid && ({1'b0, in_ch} < NCH)) begin
              r_ch    <= in_ch;
              r_raw   <= in_raw;
              r_state <= ST_SUB;
            end
          end
          ST_SUB: begin
            r_diff  <= $signed({{9{r_raw[23]}}, r_raw})
                       - sext33(w_tare[r_ch]);
            r_scale <= w_scale[r_ch];
            r_state <= ST_MUL;
          end
          ST_MUL: begin
            net_valid <= 1'b1;
            net_ch    <= r_ch;
            r_state   <= ST_CMP;
          end
          ST_CMP: begin
            if (!r_bv[r_ch]) begin
              r_base[r_ch] <= w_net;
              r_bv[r_ch]   <= 1'b1;
              r_deb[r_ch]  <= '0;
            end else if (w_evt) begin
              evt_pulse    <= 1'b1;
              evt_ch       <= r_ch;
              r_base[r_ch] <= w_net;
              r_deb[r_ch]  <= '0;
            end else if (w_over) begin
              r_deb[r_ch]  <= w_deb_n;
            end else begin
              r_deb[r_ch]  <= '0;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      // Clear beats a same-cycle increment.
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_clr[i]) begin
          r_cnt[i] <= '0;
        end else if (w_evt && (int'(r_ch) == i)
                     && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

`ifdef HOME_INV_EVT_TIMESTAMP_EN
  logic [31:0] r_tsc;

  // evt_ts shows the counter value of the cycle in which evt_pulse is high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tsc  <= '0;
      evt_ts <= '0;
    end else begin
      r_tsc <= r_tsc + 32'd1;
      if (w_evt) evt_ts <= r_tsc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_home_inventory_evt_detect.sv
// Directed scoreboard bench for home_inventory_evt_detect.
// Expected net values are queued at drive time and popped at net_valid.
module tb_home_inventory_evt_detect;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_ch;
  logic [23:0]  in_raw;
  logic [127:0] tare_flat;
  logic [127:0] scale_flat;
  logic [31:0]  thresh;
  logic [3:0]   cnt_clr;
  logic         net_valid;
  logic [2:0]   net_ch;
  logic [31:0]  net_data;
  logic         evt_pulse;
  logic [2:0]   evt_ch;
  logic [127:0] evt_count_flat;
`ifdef HOME_INV_EVT_TIMESTAMP_EN
  logic [31:0]  evt_ts;
`endif

  always #5 clk = ~clk;

  home_inventory_evt_detect #(.NUM_CH(4), .DEBOUNCE(2)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ch          (in_ch),
    .in_raw         (in_raw),
    .tare_flat      (tare_flat),
    .scale_flat     (scale_flat),
    .thresh         (thresh),
    .cnt_clr        (cnt_clr),
    .net_valid      (net_valid),
    .net_ch         (net_ch),
    .net_data       (net_data),
    .evt_pulse      (evt_pulse),
    .evt_ch         (evt_ch),
`ifdef HOME_INV_EVT_TIMESTAMP_EN
    .evt_ts         (evt_ts),
`endif
    .evt_count_flat (evt_count_flat)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] net;
  } exp_t;

  exp_t        sb[$];
  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] tb_cyc;

  logic [31:0] mb [4];
  bit          mv [4];
  int          md [4];
  logic [31:0] mc [4];

  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] calc(input logic [23:0] raw,
                                       input logic [31:0] tare,
                                       input logic [31:0] sc);
    logic signed [65:0] d, s, p;
    d = $signed({{42{raw[23]}}, raw}) - $signed({{34{tare[31]}}, tare});
    s = $signed({34'd0, sc});
    p = (d * s) >>> 16;
    if (p > 66'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (p < -66'sh80000000) return 32'h80000000;
    return p[31:0];
  endfunction

  function automatic logic [127:0] mcnt();
    return {mc[3], mc[2], mc[1], mc[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mb[i] = '0; mv[i] = 0; md[i] = 0; mc[i] = '0;
    end
  endtask

  task automatic model_disable();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0; md[i] = 0;
    end
  endtask

  task automatic model_step(input int ch, input logic [31:0] net,
                            input logic [3:0] clr, output bit ev);
    logic signed [32:0] d;
    logic [32:0]        ad;
    ev = 0;
    if (!mv[ch]) begin
      mb[ch] = net; mv[ch] = 1; md[ch] = 0;
    end else begin
      d  = $signed({net[31], net}) - $signed({mb[ch][31], mb[ch]});
      ad = d[32] ? -d : d;
      if (ad > {1'b0, thresh}) begin
        md[ch]++;
        if (md[ch] == 2) begin
          ev = 1; mb[ch] = net; md[ch] = 0;
          if (mc[ch] != 32'hFFFFFFFF) mc[ch] = mc[ch] + 1;
        end
      end else begin
        md[ch] = 0;
      end
    end
    for (int i = 0; i < 4; i++) if (clr[i]) mc[i] = '0;
  endtask

  // Call at a negedge; returns at a negedge.
  task automatic send(input logic [2:0] ch, input logic [23:0] raw,
                      input logic [3:0] clr, input string tag);
    int   n;
    bit   got, ev;
    exp_t e;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, in_ready, 1);
    in_valid = 1; in_ch = ch; in_raw = raw;
    @(posedge clk); #1 in_valid = 0;
    if (ch < 4) begin
      sb.push_back('{ch, calc(raw, tare_flat[32*ch +: 32],
                              scale_flat[32*ch +: 32])});
      got = 0;
      for (int k = 1; k <= 6 && !got; k++) begin
        @(negedge clk);
        if (net_valid) begin
          got = 1;
          chk({tag, "_lat"}, k, 3);
        end
      end
      chk({tag, "_nv"}, got, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (got) begin
          chk({tag, "_ch"}, net_ch, e.ch);
          chk({tag, "_net"}, net_data, e.net);
        end
        model_step(int'(e.ch), e.net, clr, ev);
      end
      cnt_clr = clr;
      @(posedge clk); #1 cnt_clr = '0;
      @(negedge clk);
      chk({tag, "_evt"}, evt_pulse, ev);
      if (ev) begin
        chk({tag, "_evch"}, evt_ch, ch);
`ifdef HOME_INV_EVT_TIMESTAMP_EN
        chk({tag, "_ts"}, evt_ts, tb_cyc);
`endif
      end
      chk({tag, "_cnt"}, evt_count_flat, mcnt());
    end else begin
      got = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (net_valid || evt_pulse) got = 1;
      end
      chk({tag, "_drop"}, got, 0);
      chk({tag, "_rdy2"}, in_ready, 1);
    end
  endtask

  initial begin
    bit seen;
    rst = 1; enable = 0; in_valid = 0; in_ch = '0; in_raw = '0;
    tare_flat = '0; thresh = 32'd100; cnt_clr = '0;
    scale_flat = {4{32'h0001_0000}};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_nv", net_valid, 0);
    chk("rst_evt", evt_pulse, 0);
    chk("rst_net", net_data, 0);
    chk("rst_evch", evt_ch, 0);
    chk("rst_cnt", evt_count_flat, 0);
    chk("rst_rdy_dis", in_ready, 0);
    enable = 1;
    @(negedge clk);

    // Baseline and debounce on ch0.
    send(0, 24'd500, 4'b0, "t1");
    chk("t1_net500", net_data, 32'd500);
    send(0, 24'd650, 4'b0, "t2a");
    send(0, 24'd650, 4'b0, "t2b");
    chk("t2_cnt0", evt_count_flat[31:0], 1);
    send(0, 24'd650, 4'b0, "t2c");

    // Alternating ch1 resets the debounce count.
    send(1, 24'd500, 4'b0, "t3a");
    send(1, 24'd650, 4'b0, "t3b");
    send(1, 24'd500, 4'b0, "t3c");
    send(1, 24'd650, 4'b0, "t3d");
    chk("t3_cnt1", evt_count_flat[63:32], 0);

    // Equality with thresh is within; 101 over fires.
    send(1, 24'd600, 4'b0, "t3e");
    send(1, 24'd601, 4'b0, "t3f");
    send(1, 24'd601, 4'b0, "t3g");
    chk("t3_cnt1b", evt_count_flat[63:32], 1);

    // Calibration and saturation.
    tare_flat[95:64]  = 32'h0000_1000;
    scale_flat[95:64] = 32'h0002_0000;
    send(2, 24'h001800, 4'b0, "t4a");
    chk("t4a_k", net_data, 32'h0000_1000);
    tare_flat[95:64]  = 32'h8000_0000;
    scale_flat[95:64] = 32'h7FFF_FFFF;
    send(2, 24'h7FFFFF, 4'b0, "t4b");
    chk("t4b_sat", net_data, 32'h7FFF_FFFF);
    tare_flat[127:96]  = 32'h7FFF_FFFF;
    scale_flat[127:96] = 32'h7FFF_FFFF;
    send(3, 24'h800000, 4'b0, "t4c");
    chk("t4c_sat", net_data, 32'h8000_0000);
    tare_flat[127:96]  = 32'hFFFF_FF00;
    scale_flat[127:96] = 32'h0000_8000;
    send(3, 24'hFFFF00, 4'b0, "t4d");

    // Clear in the CMP cycle of an event wins over the increment.
    send(0, 24'd800, 4'b0, "t5a");
    send(0, 24'd800, 4'b0001, "t5b");
    chk("t5_cnt0", evt_count_flat[31:0], 0);
    cnt_clr = 4'b0010;
    @(posedge clk); #1 cnt_clr = '0;
    mc[1] = '0;
    @(negedge clk);
    chk("t5_clr1", evt_count_flat, mcnt());

    // Disable during MUL drops the sample and the baselines.
    in_valid = 1; in_ch = 3'd0; in_raw = 24'd999;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    enable = 0;
    model_disable();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (net_valid || evt_pulse) seen = 1;
    end
    chk("t6_drop", seen, 0);
    chk("t6_rdy_dis", in_ready, 0);
    chk("t6_cnt_kept", evt_count_flat, mcnt());
    enable = 1;
    @(negedge clk);
    send(5, 24'd123, 4'b0, "t6_badch");
    send(0, 24'd650, 4'b0, "t6a");
    send(0, 24'd900, 4'b0, "t6b");
    send(0, 24'd900, 4'b0, "t6c");
    chk("t6_cnt0", evt_count_flat[31:0], 1);

    // Reset mid-flight clears counts too.
    in_valid = 1; in_ch = 3'd1; in_raw = 24'd42;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    sb.delete();
    @(negedge clk);
    chk("t7_cnt", evt_count_flat, 0);
    chk("t7_nv", net_valid, 0);
    chk("t7_rdy", in_ready, 1);
    send(1, 24'd10, 4'b0, "t7a");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
